// File: rtl/iob_native_ram_resp.sv
// Responder end of the IOb native memory bus: one request at a time, a fixed
// number of wait states, then a single-cycle ready pulse carrying rdata.
module iob_native_ram_resp #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_ADDR_W  = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ready
);

    localparam int         STRB_W    = DATA_W / 8;
    localparam int         DEPTH     = 2 ** MEM_ADDR_W;
    localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                 state;
    logic [7:0]             wait_cnt;
    logic [MEM_ADDR_W-1:0]  req_idx_p0;
    logic [DATA_W-1:0]      req_wdata_p0;
    logic [STRB_W-1:0]      req_wstrb_p0;
    logic [DATA_W-1:0]      mem [DEPTH];

    // Byte-offset and upper address bits alias onto the same word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address[ADDR_W-1:MEM_ADDR_W+2], address[1:0]};

    // Stage p0: request captured on acceptance, held until the access completes
    always_ff @(posedge clk) begin
        if (state == S_IDLE && valid) begin
            req_idx_p0   <= address[MEM_ADDR_W+1:2];
            req_wdata_p0 <= wdata;
            req_wstrb_p0 <= wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_ACCESS) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (req_wstrb_p0[b]) begin
                    mem[req_idx_p0][b*8 +: 8] <= req_wdata_p0[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            ready    <= 1'b0;
            rdata    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready <= 1'b0;
                    rdata <= '0;
                    if (valid) begin
                        wait_cnt <= WAIT_INIT;
                        state    <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 8'd1;
                    if (wait_cnt == 8'd1) begin
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Writes answer with zero data; reads return the stored word.
                    ready <= 1'b1;
                    rdata <= (req_wstrb_p0 == '0) ? mem[req_idx_p0] : '0;
                    state <= S_RESP;
                end
                S_RESP: begin
                    ready <= 1'b0;
                    rdata <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_native_ram_resp.sv
// Bench for iob_native_ram_resp: three instances (0, 1 and 5 wait states)
// driven by directed and randomized transactions against a word-map model.
module tb_iob_native_ram_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid   [3];
    logic [31:0] address [3];
    logic [31:0] wdata   [3];
    logic [3:0]  wstrb   [3];
    logic [31:0] rdata   [3];
    logic        ready   [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_ready_cyc;
    int pulses     [3];
    int dbl        [3];
    logic prev_rdy [3];

    logic [31:0] ref_mem [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        iob_native_ram_resp #(
            .DATA_W(32),
            .ADDR_W(32),
            .MEM_ADDR_W(12),
            .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 5))
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .valid(valid[g]),
            .address(address[g]),
            .wdata(wdata[g]),
            .wstrb(wstrb[g]),
            .rdata(rdata[g]),
            .ready(ready[g])
        );
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            pulses[i]   = 0;
            dbl[i]      = 0;
            prev_rdy[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ready[i]) pulses[i] = pulses[i] + 1;
            if (ready[i] && prev_rdy[i]) dbl[i] = dbl[i] + 1;
            prev_rdy[i] = ready[i];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int wc(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 5);
    endfunction

    function automatic int key(input int k, input logic [31:0] a);
        return k * 4096 + int'(a[13:2]);
    endfunction

    function automatic logic [31:0] ref_read(input int k, input logic [31:0] a);
        int kk = key(k, a);
        return ref_mem.exists(kk) ? ref_mem[kk] : 32'h0;
    endfunction

    task automatic ref_write(input int k, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        int kk = key(k, a);
        logic [31:0] w = ref_mem.exists(kk) ? ref_mem[kk] : 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
        end
        ref_mem[kk] = w;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One transaction on instance k; inputs are scrambled while it is in flight.
    task automatic txn(input int k, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit drop_early, output logic [31:0] rd);
        int lat;
        logic [31:0] exp_rd;
        @(posedge clk); #1;
        check("idle_ready", 32'(ready[k]), 32'h0);
        check("idle_rdata", rdata[k], 32'h0);
        exp_rd     = (s != 4'h0) ? 32'h0 : ref_read(k, a);
        valid[k]   = 1'b1;
        address[k] = a;
        wdata[k]   = d;
        wstrb[k]   = s;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!ready[k]) begin
                address[k] = $urandom;
                wdata[k]   = $urandom;
                wstrb[k]   = 4'($urandom);
                if (drop_early) valid[k] = 1'b0;
            end
        end while (!ready[k] && lat < 40);
        valid[k] = 1'b0;
        rd = rdata[k];
        last_ready_cyc = cyc;
        check("latency", 32'(lat), 32'(2 + wc(k)));
        check("rdata", rd, exp_rd);
        if (s != 4'h0) ref_write(k, a, d, s);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] addrs [8];
        logic [3:0]  s;
        int          p0;
        int          prev_cyc;
        int          k;
        int          lat;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid[i]   = 1'b0;
            address[i] = '0;
            wdata[i]   = '0;
            wstrb[i]   = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_ready", 32'(ready[i]), 32'h0);
            check("reset_rdata", rdata[i], 32'h0);
        end
        @(negedge clk) rst = 1'b0;

        // Write-then-read, one wait state
        txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd);
        check("wr_rdata_zero", rd, 32'h0);
        txn(1, 32'h10, 32'h0, 4'h0, 1'b0, rd);
        check("rd_deadbeef", rd, 32'hDEADBEEF);

        // Partial byte strobes
        txn(1, 32'h20, 32'h11223344, 4'hF, 1'b0, rd);
        txn(1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, rd);
        txn(1, 32'h20, 32'h0, 4'h0, 1'b0, rd);
        check("strobe_0101", rd, 32'h11BB33DD);

        // Back-to-back wrapper-style reads on each wait-state setting
        for (int kk = 0; kk < 3; kk++) begin
            for (int i = 0; i < 8; i++) begin
                addrs[i] = {18'b0, 12'($urandom), 2'b00};
                txn(kk, addrs[i], $urandom, 4'hF, 1'b0, rd);
            end
            @(negedge clk); #1;
            p0 = pulses[kk];
            prev_cyc = 0;
            for (int i = 0; i < 8; i++) begin
                txn(kk, addrs[i], 32'h0, 4'h0, 1'b0, rd);
                if (i > 0) check("b2b_spacing", 32'(last_ready_cyc - prev_cyc), 32'(3 + wc(kk)));
                prev_cyc = last_ready_cyc;
            end
            @(negedge clk); #1;
            check("b2b_pulses", 32'(pulses[kk] - p0), 32'd8);
        end

        // Upper address bits alias onto the same word
        d = $urandom;
        a = 32'h40 | ($urandom << 14);
        txn(0, a, d, 4'hF, 1'b0, rd);
        txn(0, 32'h40, 32'h0, 4'h0, 1'b0, rd);
        check("alias_read", rd, d);

        // Randomized mix over a preloaded pool of words
        for (int kk = 0; kk < 3; kk++) begin
            for (int i = 0; i < 8; i++) begin
                txn(kk, 32'h100 + 32'(4 * i), $urandom, 4'hF, 1'b0, rd);
            end
        end
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 2);
            a = (32'h100 + 32'(4 * $urandom_range(0, 7))) | (32'($urandom_range(0, 3)) << 14);
            s = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            txn(k, a, $urandom, s, ($urandom_range(0, 3) == 0), rd);
        end

        // Reset during the response cycle clears outputs asynchronously
        txn(1, 32'h30, 32'h12345678, 4'hF, 1'b0, rd);
        @(posedge clk); #1;
        valid[1] = 1'b1; address[1] = 32'h30; wstrb[1] = 4'h0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ready[1] && lat < 40);
        valid[1] = 1'b0;
        check("pre_reset_rdata", rdata[1], 32'h12345678);
        rst = 1'b1;
        #1;
        check("async_clr_ready", 32'(ready[1]), 32'h0);
        check("async_clr_rdata", rdata[1], 32'h0);
        @(negedge clk) rst = 1'b0;

        // Reset during the wait state discards the in-flight write
        @(posedge clk); #1;
        valid[1] = 1'b1; address[1] = 32'h30; wdata[1] = 32'hFFFFFFFF; wstrb[1] = 4'hF;
        @(posedge clk); #1;
        rst = 1'b1;
        valid[1] = 1'b0;
        #1;
        check("wait_rst_ready", 32'(ready[1]), 32'h0);
        check("wait_rst_rdata", rdata[1], 32'h0);
        @(negedge clk) rst = 1'b0;
        txn(1, 32'h30, 32'h0, 4'h0, 1'b0, rd);
        check("write_discarded", rd, 32'h12345678);

        for (int i = 0; i < 3; i++) begin
            check("single_cycle_ready", 32'(dbl[i]), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iob_native_ram_resp.md
Name: iob_native_ram_resp

Overview:
- Responder (slave) end of the IOb native memory bus, i.e. the block that answers requests from the CPU wrapper's instruction or data bus.
- Accepts one request at a time (valid/address/wdata/wstrb) and answers with a single-cycle ready pulse plus rdata.
- Backed by an internal word-organised RAM with byte-write enables and a programmable number of wait states.
- Used as boot/scratch memory and as a bench target for initiator-side verification.

Parameters:
- DATA_W, 32, data width in bits; must be 32. wstrb width is DATA_W/8.
- ADDR_W, 32, width of the incoming byte address.
- MEM_ADDR_W, 12, log2 of RAM depth in words; depth = 2**MEM_ADDR_W.
- WAIT_CYCLES, 1, extra cycles inserted between request acceptance and ready; range 0..255.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- valid  input  1  request valid; initiator holds until ready, drops same cycle ready seen
- address  input  ADDR_W  byte address; bits [1:0] and bits above MEM_ADDR_W+1 ignored
- wdata  input  DATA_W  write data
- wstrb  input  DATA_W/8  byte write enables; all-zero = read
- rdata  output  DATA_W  read data, valid only while ready=1
- ready  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, active-high): ready=0, rdata=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
- Word index is address[MEM_ADDR_W+1:2]. Upper address bits alias, with no error response.
- FSM states:
  - IDLE: if valid=1, capture address/wdata/wstrb into request registers and load counter=WAIT_CYCLES. Go to WAIT, or to ACCESS when WAIT_CYCLES=0.
  - WAIT: decrement the counter each cycle. At counter==1 go to ACCESS. Inputs are ignored; captured values are used.
  - ACCESS: perform the RAM operation from the captured registers.
    - Write (wstrb!=0): update only the bytes whose strobe bit is set.
    - Read: synchronous read of the word.
    - Go to RESP.
  - RESP: ready=1 for exactly this cycle. rdata = read word for reads, 0 for writes. Next state is IDLE.
- Latency: valid first high in cycle N (FSM in IDLE) -> ready high in cycle N+2+WAIT_CYCLES.
  - WAIT_CYCLES=0: ready in N+2.
  - WAIT_CYCLES=1: ready in N+3.
- ready is never high in two consecutive cycles. rdata returns to 0 in the cycle after ready.
- valid still high in the RESP cycle is not a new request; it is sampled only in IDLE. Earliest next acceptance is the cycle after ready. Back-to-back throughput is one transaction per 3+WAIT_CYCLES cycles.
- Inputs that change after acceptance have no effect on the in-flight transaction.
- valid dropping before ready (protocol violation): the transaction still completes and ready still pulses.
- Reset asserted mid-transaction: outputs clear immediately, and the in-flight write is discarded if ACCESS was not yet reached.
- Partial strobes (e.g. 4'b0101) update only bytes 0 and 2.

Test Plan:
- Write-then-read, WAIT_CYCLES=1: write address=0x10, wdata=0xDEADBEEF, wstrb=4'hF; then read 0x10 -> each ready exactly 3 cycles after valid; read rdata=0xDEADBEEF; write rdata=0.
- Byte strobes: preload 0x11223344 at 0x20, write wdata=0xAABBCCDD with wstrb=4'b0101 -> read returns 0x11BB33DD.
- Latency sweep: WAIT_CYCLES=0, 1, 5 -> ready at N+2, N+3, N+7; ready is a single-cycle pulse each time.
- Back-to-back with the wrapper-style initiator (valid = req & ~ready) issuing 8 consecutive reads -> 8 ready pulses, no duplicate or lost transactions, ready spacing = 3+WAIT_CYCLES.
- Input stability: change address/wdata during WAIT -> the captured values are used; write lands at the original address.
- Reset mid-operation: assert rst in the WAIT state of a write to 0x30 -> ready and rdata go 0 asynchronously; 0x30 keeps its old value; first request after reset completes normally.
